calc_display_ctrl: RTL and testbench

- Display scheduler between the calculator core and an 8-digit multiplexed 7-segment display.
- Consumes the core's `dig`/`pos`/`status` stream and assembles it into an 8-digit frame buffer:
  - shift-in during operand entry;
  - direct positional writes during result print.
- Time-shares the single segment bus across the 8 digits with a refresh scan.
- Overrides the display with an error pattern when the core reports `ERRO`.

---
 rtl/calc_display_ctrl.sv | 143 ++++++++++++++
 tb/tb_calc_display_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_display_ctrl.sv
// Display scheduler: frame buffer assembly, refresh scan and error override.
// Optional: CALC_DISP_LZ_BLANK_EN blanks leading zeros outside ERROR.
module calc_display_ctrl #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] dig,
    input  logic [3:0] pos,
    input  logic       dig_valid,
    input  logic [1:0] status,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic [1:0] mode
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [1:0] ST_ERRO   = 2'd0;
    localparam logic [1:0] ST_PRONTA = 2'd1;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        RESULT = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      frame     [8];
    logic [3:0]      frame_nxt [8];
    logic [DW-1:0]   div;
    logic [2:0]      idx;
    logic            tc;
    logic [7:0]      nz_upto;
    logic            lz_blank;
    logic [6:0]      seg_nxt;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        for (int i = 0; i < 8; i++) frame_nxt[i] = frame[i];
        if (status == ST_ERRO) begin
            state_nxt = ERROR;
        end else begin
            unique case (state)
                IDLE, ENTRY: begin
                    if (dig_valid && pos == 4'd0) begin
                        for (int i = 0; i < 7; i++)
                            frame_nxt[i] = (state == IDLE) ? 4'd0 : frame[i+1];
                        frame_nxt[7] = dig;
                        state_nxt    = ENTRY;
                    end else if (dig_valid && pos == 4'd7) begin
                        for (int i = 0; i < 7; i++) frame_nxt[i] = 4'd0;
                        frame_nxt[7] = dig;
                        state_nxt    = RESULT;
                    end
                end
                RESULT: begin
                    // Write lands even when PRONTA closes the print
                    if (dig_valid && !pos[3])
                        frame_nxt[pos[2:0]] = dig;
                    if (status == ST_PRONTA)
                        state_nxt = IDLE;
                end
                ERROR: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            for (int i = 0; i < 8; i++) frame[i] <= 4'd0;
        end else begin
            state <= state_nxt;
            for (int i = 0; i < 8; i++) frame[i] <= frame_nxt[i];
        end
    end

    assign tc = (div == DW'(REFRESH_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div <= '0;
            idx <= 3'd0;
        end else begin
            div <= tc ? '0 : div + 1'b1;
            if (tc) idx <= idx + 3'd1;
        end
    end

    always_comb begin
        nz_upto[0] = (frame[0] != 4'd0);
        for (int i = 1; i < 8; i++)
            nz_upto[i] = nz_upto[i-1] | (frame[i] != 4'd0);
    end

`ifdef CALC_DISP_LZ_BLANK_EN
    assign lz_blank = !nz_upto[idx] && (idx != 3'd7);
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_nxt = enc(frame[idx]);
        if (state == ERROR)
            seg_nxt = (idx == 3'd7) ? SEG_E : SEG_BLANK;
        else if (lz_blank)
            seg_nxt = SEG_BLANK;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
        end else begin
            an  <= ~(8'h01 << idx);
            seg <= seg_nxt;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Directed bench for calc_display_ctrl with REFRESH_DIV=2.
// Frame expectations are given as 8 hex digits, leftmost = position 0.
module tb_calc_display_ctrl;

    logic       clock;
    logic       reset;
    logic [3:0] dig;
    logic [3:0] pos;
    logic       dig_valid;
    logic [1:0] status;
    logic [7:0] an;
    logic [6:0] seg;
    logic [1:0] mode;

    int checks;
    int failures;

    calc_display_ctrl #(.REFRESH_DIV(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .dig       (dig),
        .pos       (pos),
        .dig_valid (dig_valid),
        .status    (status),
        .an        (an),
        .seg       (seg),
        .mode      (mode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = 7'b1111111;
        endcase
    endfunction

    function automatic logic [55:0] frame_segs(input logic [31:0] f);
        logic [55:0] r;
        logic [3:0]  d;
        logic        seen;
        r    = '0;
        seen = 1'b0;
        for (int p = 0; p < 8; p++) begin
            d = f[(7-p)*4 +: 4];
            seen = seen | (d != 4'd0);
            r[p*7 +: 7] = enc(d);
`ifdef CALC_DISP_LZ_BLANK_EN
            if (!seen && p != 7) r[p*7 +: 7] = 7'b1111111;
`endif
        end
        return r;
    endfunction

    task automatic check_segs(input string tag, input logic [55:0] segs);
        logic [7:0] exp_an;
        int n;
        for (int p = 0; p < 8; p++) begin
            exp_an = ~(8'h01 << p);
            n = 0;
            while (an != exp_an && n < 40) begin
                @(negedge clock);
                n++;
            end
            check({tag, "_an"}, an, exp_an);
            check({tag, "_seg"}, seg, segs[p*7 +: 7]);
        end
    endtask

    task automatic check_frame(input string tag, input logic [31:0] f);
        check_segs(tag, frame_segs(f));
    endtask

    task automatic strobe(input logic [3:0] d, input logic [3:0] p);
        dig       = d;
        pos       = p;
        dig_valid = 1'b1;
        @(negedge clock);
        dig_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    logic [55:0] zsegs;
    logic [55:0] esegs;
    logic [7:0]  exp_an;

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        status    = 2'd1;
        dig       = 4'd0;
        pos       = 4'd0;
        dig_valid = 1'b0;
        zsegs     = frame_segs(32'h0);

        repeat (3) @(negedge clock);
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_mode", mode, 2'd0);
        reset = 1'b0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clock);
            exp_an = ~(8'h01 << ((k / 2) % 8));
            check("scan_an", an, exp_an);
            check("scan_seg", seg, zsegs[((k / 2) % 8)*7 +: 7]);
        end
        check("scan_mode", mode, 2'd0);

        // operand entry
        status = 2'd2;
        strobe(4'd1, 4'd0);
        strobe(4'd2, 4'd0);
        strobe(4'd3, 4'd0);
        check("entry_mode", mode, 2'd1);
        check_frame("entry", 32'h00000123);

        // result print over a fresh entry
        do_reset();
        status = 2'd2;
        strobe(4'd1, 4'd0);
        strobe(4'd2, 4'd0);
        check_frame("pre_res", 32'h00000012);
        status = 2'd3;
        strobe(4'd5, 4'd7);
        check("res_mode", mode, 2'd2);
        strobe(4'd4, 4'd6);
        for (int q = 5; q >= 0; q--) strobe(4'd0, 4'(q));
        strobe(4'd2, 4'd8);
        check("res_mode2", mode, 2'd2);
        status = 2'd1;
        @(negedge clock);
        check("res_done", mode, 2'd0);
        status = 2'd2;
        strobe(4'd6, 4'd3);
        check("idle_ign", mode, 2'd0);
        check_frame("result", 32'h00000045);

        // nine entry digits, ignored positions
        do_reset();
        status = 2'd2;
        for (int d = 1; d <= 9; d++) strobe(4'(d), 4'd0);
        strobe(4'd7, 4'd3);
        strobe(4'd7, 4'd9);
        check("nine_mode", mode, 2'd1);
        check_frame("nine", 32'h23456789);

        // error with simultaneous strobe
        status    = 2'd0;
        dig       = 4'd4;
        pos       = 4'd0;
        dig_valid = 1'b1;
        @(negedge clock);
        dig_valid = 1'b0;
        status    = 2'd2;
        check("err_mode", mode, 2'd3);
        strobe(4'd5, 4'd0);
        strobe(4'd6, 4'd7);
        check("err_hold", mode, 2'd3);
        esegs = {7'b0000110, {7{7'b1111111}}};
        check_segs("err", esegs);

        // reset in the middle of a result print
        do_reset();
        status = 2'd3;
        strobe(4'd5, 4'd7);
        strobe(4'd3, 4'd6);
        check("mid_mode", mode, 2'd2);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_an", an, 8'hFF);
        check("mid_rst_seg", seg, 7'h7F);
        check("mid_rst_mode", mode, 2'd0);
        reset = 1'b0;
        @(negedge clock);
        check("mid_an", an, 8'hFE);
        check("mid_mode0", mode, 2'd0);
        check_frame("mid", 32'h00000000);

        // final write together with PRONTA
        status = 2'd3;
        strobe(4'd8, 4'd7);
        dig       = 4'd9;
        pos       = 4'd7;
        dig_valid = 1'b1;
        status    = 2'd1;
        @(negedge clock);
        dig_valid = 1'b0;
        check("wp_mode", mode, 2'd0);
        check_frame("wp", 32'h00000009);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
